// File: rtl/ifu_prefetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding and fetch constants.
package ifu_defines;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifu_state;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Synchronous FIFO with flush; head word is read combinationally from storage.
module fifo_sync #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign rdata  = mem[rd_ptr];
  assign pop_ok = pop && !empty;

  // The writer only pushes when an entry is free or the head leaves this same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch front end: one outstanding memory fetch feeding a DEPTH-entry FIFO,
// with PC redirect flushing queued work and discarding any in-flight response.
module ifu_prefetch
  import ifu_defines::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = ifu_defines::RESET_PC
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic            reqValid,
  output logic [XLEN-1:0] addr,
  input  logic            respValid,
  input  logic [XLEN-1:0] rdata
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ifu_state        state, state_next;
  logic [XLEN-1:0] fetch_pc, pc_next;
  logic [XLEN-1:0] addr_next;
  logic            req_next;
  logic            resp_accept;
  logic            pop;
  logic            push;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [2*XLEN-1:0] fifo_head;
  logic [XLEN-1:0] redirect_aligned;

  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign inst_valid       = !fifo_empty;
  assign inst             = fifo_head[XLEN-1:0];
  assign inst_pc          = fifo_head[2*XLEN-1:XLEN];
  assign pop              = inst_valid && inst_ready && !redirect_valid;
  assign push             = resp_accept && (!fifo_full || pop);

  always_comb begin
    state_next  = state;
    req_next    = reqValid;
    addr_next   = addr;
    pc_next     = fetch_pc;
    resp_accept = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect_valid && (fifo_count < CW'(DEPTH))) begin
          req_next   = 1'b1;
          addr_next  = fetch_pc;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          if (respValid) begin
            req_next   = 1'b0;
            state_next = IDLE;
          end else begin
            state_next = DROP;
          end
        end else if (respValid) begin
          resp_accept = 1'b1;
          pc_next     = fetch_pc + XLEN'(PC_STEP);
          req_next    = 1'b0;
          state_next  = IDLE;
        end
      end
      DROP: begin
        // Keep the request up until memory answers; the answer itself is thrown away.
        if (respValid) begin
          req_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (redirect_valid) pc_next = redirect_aligned;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      reqValid <= 1'b0;
      addr     <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= pc_next;
      reqValid <= req_next;
      addr     <= addr_next;
    end
  end

  fifo_sync #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({addr, rdata}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
